// File: rtl/button_gesture_decoder.sv
// Classifies debounced push-button activity into single-cycle gesture pulses:
// short press, double click, long press and auto-repeat while held.
module button_gesture_decoder #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 40000,
  parameter int DCLICK_TICKS = 20000,
  parameter int REPEAT_TICKS = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_state,
  input  logic btn_down,
  input  logic btn_up,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             down_v;
  logic             release_v;

  // Simultaneous press and release pulses cancel each other out.
  always_comb begin
    down_v    = btn_down & ~btn_up;
    release_v = (btn_up & ~btn_down) | ~btn_state;
  end

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      cnt          <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

      // Every transition clears the counter and updates busy from the next state.
      case (state)
        IDLE: begin
          if (down_v) begin
            state <= PRESS1;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        PRESS1: begin
          if (release_v) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
            cnt        <= '0;
          end
        end

        WAIT2: begin
          if (cnt == DCLICK_LAST) begin
            short_press <= 1'b1;
            cnt         <= '0;
            if (down_v) begin
              state <= PRESS1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (down_v) begin
            state <= PRESS2;
            cnt   <= '0;
          end
        end

        PRESS2: begin
          if (release_v) begin
            double_click <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
            cnt        <= '0;
          end
        end

        HELD: begin
          if (release_v) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_tick <= 1'b1;
            cnt         <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench for button_gesture_decoder: expected pulses are queued per
// test and compared against the DUT outputs every cycle.
module tb_button_gesture_decoder;

  localparam int CNT_W        = 8;
  localparam int LONG_TICKS   = 20;
  localparam int DCLICK_TICKS = 10;
  localparam int REPEAT_TICKS = 5;

  localparam logic [3:0] P_SHORT  = 4'b1000;
  localparam logic [3:0] P_DOUBLE = 4'b0100;
  localparam logic [3:0] P_LONG   = 4'b0010;
  localparam logic [3:0] P_REPEAT = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_state;
  logic btn_down;
  logic btn_up;
  logic short_press;
  logic double_click;
  logic long_press;
  logic repeat_tick;
  logic busy;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];   // expected pulse vectors, ascending cycle
  exp_t bq[$];   // expected busy values, ascending cycle
  int   dq[$];   // cycles carrying btn_down
  int   uq[$];   // cycles carrying btn_up

  button_gesture_decoder #(
    .CNT_W       (CNT_W),
    .LONG_TICKS  (LONG_TICKS),
    .DCLICK_TICKS(DCLICK_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_state   (btn_state),
    .btn_down    (btn_down),
    .btn_up      (btn_up),
    .short_press (short_press),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit has(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] pulses();
    return {short_press, double_click, long_press, repeat_tick};
  endfunction

  task automatic push_pulse(input int cyc, input logic [3:0] val);
    exp_t e;
    e.cyc = cyc;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_busy(input int cyc, input logic val);
    exp_t e;
    e.cyc = cyc;
    e.val = {3'b000, val};
    bq.push_back(e);
  endtask

  // Cycle t: inputs are applied before edge t; outputs are sampled 1 ns after it.
  task automatic run(input string name, input int len);
    logic [3:0] exp_p;
    for (int t = 0; t < len; t++) begin
      btn_down = has(dq, t);
      btn_up   = has(uq, t);
      if (btn_down && !btn_up) btn_state = 1'b1;
      if (btn_up && !btn_down) btn_state = 1'b0;
      @(posedge clk);
      #1;
      exp_p = 4'b0000;
      if (sb.size() > 0 && sb[0].cyc == t) exp_p = sb.pop_front().val;
      check($sformatf("%s pulses@%0d", name, t), 32'(pulses()), 32'(exp_p));
      if (bq.size() > 0 && bq[0].cyc == t)
        check($sformatf("%s busy@%0d", name, t), 32'(busy), 32'(bq.pop_front().val[0]));
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
    check({name, " sb_drain"}, 32'(sb.size() + bq.size()), 32'd0);
    sb.delete();
    bq.delete();
    dq.delete();
    uq.delete();
  endtask

  initial begin
    rst       = 1'b1;
    btn_state = 1'b0;
    btn_down  = 1'b0;
    btn_up    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pulses", 32'(pulses()), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Short press: released at 5, timeout 10 cycles later.
    dq = '{0}; uq = '{5};
    push_busy(14, 1'b1);
    push_pulse(15, P_SHORT);
    push_busy(15, 1'b0);
    run("short", 20);

    // Double click within the gap.
    dq = '{0, 8}; uq = '{4, 12};
    push_busy(11, 1'b1);
    push_pulse(12, P_DOUBLE);
    push_busy(12, 1'b0);
    run("double", 25);

    // Long press followed by auto-repeat until release at 36.
    dq = '{0}; uq = '{36};
    push_pulse(20, P_LONG);
    push_pulse(25, P_REPEAT);
    push_pulse(30, P_REPEAT);
    push_pulse(35, P_REPEAT);
    push_busy(35, 1'b1);
    push_busy(37, 1'b0);
    run("long", 45);

    // Second press lands exactly on the gap timeout: short, then a new press.
    dq = '{0, 14}; uq = '{4, 17};
    push_pulse(14, P_SHORT);
    push_busy(14, 1'b1);
    push_pulse(27, P_SHORT);
    push_busy(27, 1'b0);
    run("gap", 32);

    // Release coincides with the long-press threshold: release wins.
    dq = '{0}; uq = '{20};
    push_busy(29, 1'b1);
    push_pulse(30, P_SHORT);
    push_busy(30, 1'b0);
    run("race", 35);

    // Simultaneous down and up pulses are ignored.
    dq = '{0}; uq = '{0};
    push_busy(1, 1'b0);
    run("both", 5);

    // Async reset in HELD between repeats aborts the gesture.
    dq = '{0};
    push_pulse(20, P_LONG);
    push_pulse(25, P_REPEAT);
    push_busy(26, 1'b1);
    run("pre_rst", 28);
    #2 rst = 1'b1;
    #1;
    check("async rst pulses", 32'(pulses()), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    dq = '{3}; uq = '{1, 6};
    push_busy(2, 1'b0);
    push_busy(3, 1'b1);
    push_pulse(16, P_SHORT);
    push_busy(16, 1'b0);
    run("post_rst", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
